// File: rtl/arc4_pkg.sv
// Constants and state encoding shared by the ARC4 key-search controller and
// the top-level HEX display logic.
package arc4_pkg;
    localparam int unsigned ARC4_KEY_W    = 24;
    localparam logic [7:0]  ARC4_ASCII_LO = 8'h20;
    localparam logic [7:0]  ARC4_ASCII_HI = 8'h7E;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LAUNCH    = 4'd1,
        ST_WAIT_BUSY = 4'd2,
        ST_WAIT_DONE = 4'd3,
        ST_RD_LEN    = 4'd4,
        ST_SCAN      = 4'd5,
        ST_NEXT      = 4'd6,
        ST_FOUND     = 4'd7,
        ST_DONE      = 4'd8
    } crack_state_t;
endpackage

// File: rtl/ascii_check.sv
// Range compare of one plaintext byte against the accepted printable window.
module ascii_check #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic [7:0] byte_i,
    output logic       ok_o
);
    assign ok_o = (byte_i >= LO) && (byte_i <= HI);
endmodule

// File: rtl/arc4_crack_ctrl.sv
// Brute-force key search: runs the arc4 core once per candidate key and scans
// the plaintext it wrote, stopping on the first all-printable result.
//
// state        | meaning
// IDLE         | rdy high, waiting for en
// LAUNCH       | wait for core idle, then pulse arc4_en with current candidate
// WAIT_BUSY    | wait for core to drop rdy (ignores stale rdy after the pulse)
// WAIT_DONE    | wait for core to finish, point pt_addr at the length byte
// RD_LEN       | two cycles: cover read latency, then capture length
// SCAN         | check bytes 1..len, one read in flight
// NEXT         | step candidate or give up when the key space is exhausted
// FOUND        | latch the winning key
// DONE         | raise rdy and return to IDLE
module arc4_crack_ctrl import arc4_pkg::*; #(
    parameter int unsigned      KEY_W     = ARC4_KEY_W,
    parameter logic [KEY_W-1:0] KEY_START = '0,
    parameter int unsigned      KEY_STEP  = 1,
    parameter logic [7:0]       ASCII_LO  = ARC4_ASCII_LO,
    parameter logic [7:0]       ASCII_HI  = ARC4_ASCII_HI
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic             rdy_o,
    output logic             key_valid_o,
    output logic [KEY_W-1:0] key_o,
    output logic             arc4_en_o,
    input  logic             arc4_rdy_i,
    output logic [KEY_W-1:0] arc4_key_o,
    output logic [7:0]       pt_addr_o,
    input  logic [7:0]       pt_rddata_i
);
    crack_state_t     state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             key_valid_q, key_valid_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic             arc4_en_q, arc4_en_d;
    logic [7:0]       pt_addr_q, pt_addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic             lat_q, lat_d;
    logic             byte_ok;
    logic [KEY_W:0]   cand_sum;

    ascii_check #(.LO(ASCII_LO), .HI(ASCII_HI)) u_ascii_check (
        .byte_i (pt_rddata_i),
        .ok_o   (byte_ok)
    );

    // One extra bit so running off the top of the key space is visible.
    assign cand_sum = {1'b0, cand_q} + (KEY_W+1)'(KEY_STEP);

    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        key_valid_d = key_valid_q;
        key_d       = key_q;
        cand_d      = cand_q;
        arc4_en_d   = 1'b0;
        pt_addr_d   = pt_addr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        case (state_q)
            ST_IDLE: if (en_i) begin
                cand_d      = KEY_START;
                key_valid_d = 1'b0;
                rdy_d       = 1'b0;
                state_d     = ST_LAUNCH;
            end
            ST_LAUNCH: if (arc4_rdy_i) begin
                arc4_en_d = 1'b1;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: if (!arc4_rdy_i) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (arc4_rdy_i) begin
                pt_addr_d = 8'd0;
                lat_d     = 1'b0;
                state_d   = ST_RD_LEN;
            end
            ST_RD_LEN: begin
                if (!lat_q) begin
                    lat_d     = 1'b1;
                    pt_addr_d = 8'd1;
                end else begin
                    len_d     = pt_rddata_i;
                    idx_d     = 8'd1;
                    pt_addr_d = 8'd2;
                    state_d   = (pt_rddata_i == 8'd0) ? ST_FOUND : ST_SCAN;
                end
            end
            // pt_rddata_i holds byte idx_q while address idx_q+1 is in flight.
            ST_SCAN: begin
                if (!byte_ok) begin
                    state_d = ST_NEXT;
                end else if (idx_q == len_q) begin
                    state_d = ST_FOUND;
                end else begin
                    idx_d     = idx_q + 8'd1;
                    pt_addr_d = pt_addr_q + 8'd1;
                end
            end
            ST_NEXT: begin
                if (cand_sum[KEY_W]) begin
                    state_d = ST_DONE;
                end else begin
                    cand_d  = cand_sum[KEY_W-1:0];
                    state_d = ST_LAUNCH;
                end
            end
            ST_FOUND: begin
                key_d       = cand_q;
                key_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            cand_q      <= KEY_START;
            arc4_en_q   <= 1'b0;
            pt_addr_q   <= 8'd0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            lat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            key_valid_q <= key_valid_d;
            key_q       <= key_d;
            cand_q      <= cand_d;
            arc4_en_q   <= arc4_en_d;
            pt_addr_q   <= pt_addr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
        end
    end

    assign rdy_o       = rdy_q;
    assign key_valid_o = key_valid_q;
    assign key_o       = key_q;
    assign arc4_en_o   = arc4_en_q;
    assign arc4_key_o  = cand_q;
    assign pt_addr_o   = pt_addr_q;
endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Directed bench for arc4_crack_ctrl with behavioural arc4 stubs: a 24-bit
// instance for search/reset/handshake cases and a 4-bit instance for exhaustion.
module tb_arc4_crack_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   passed = 0;

    // 24-bit instance
    logic        a_en, a_rdy, a_kv, a_arc4_en, a_arc4_rdy;
    logic [23:0] a_key, a_arc4_key;
    logic [7:0]  a_pt_addr, a_rd;
    // 4-bit instance
    logic        b_en, b_rdy, b_kv, b_arc4_en, b_arc4_rdy;
    logic [3:0]  b_key, b_arc4_key;
    logic [7:0]  b_pt_addr, b_rd;

    arc4_crack_ctrl u_dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(a_en), .rdy_o(a_rdy), .key_valid_o(a_kv),
        .key_o(a_key), .arc4_en_o(a_arc4_en), .arc4_rdy_i(a_arc4_rdy),
        .arc4_key_o(a_arc4_key), .pt_addr_o(a_pt_addr), .pt_rddata_i(a_rd)
    );

    arc4_crack_ctrl #(.KEY_W(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(b_en), .rdy_o(b_rdy), .key_valid_o(b_kv),
        .key_o(b_key), .arc4_en_o(b_arc4_en), .arc4_rdy_i(b_arc4_rdy),
        .arc4_key_o(b_arc4_key), .pt_addr_o(b_pt_addr), .pt_rddata_i(b_rd)
    );

    // Stub A: 10-cycle run, pt[0] is the plain length, pt[i] = img[i] ^ key[7:0].
    logic [7:0] img_a [0:31];
    logic [3:0] a_cnt;
    logic [7:0] a_k;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_arc4_rdy <= 1'b1; a_cnt <= 4'd0; a_k <= 8'd0; a_rd <= 8'd0;
        end else begin
            if (a_arc4_en && a_arc4_rdy) begin
                a_arc4_rdy <= 1'b0; a_cnt <= 4'd10; a_k <= a_arc4_key[7:0];
            end else if (!a_arc4_rdy) begin
                a_cnt <= a_cnt - 4'd1;
                if (a_cnt == 4'd1) a_arc4_rdy <= 1'b1;
            end
            a_rd <= (a_pt_addr == 8'd0) ? img_a[0] : (img_a[a_pt_addr[4:0]] ^ a_k);
        end
    end

    // Stub B: length 1, single byte 0x00 ^ key -> never printable for a 4-bit key.
    logic [3:0] b_cnt;
    logic [3:0] b_k;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b_arc4_rdy <= 1'b1; b_cnt <= 4'd0; b_k <= 4'd0; b_rd <= 8'd0;
        end else begin
            if (b_arc4_en && b_arc4_rdy) begin
                b_arc4_rdy <= 1'b0; b_cnt <= 4'd10; b_k <= b_arc4_key;
            end else if (!b_arc4_rdy) begin
                b_cnt <= b_cnt - 4'd1;
                if (b_cnt == 4'd1) b_arc4_rdy <= 1'b1;
            end
            b_rd <= (b_pt_addr == 8'd0) ? 8'd1 : {4'h0, b_k};
        end
    end

    int a_pulses = 0;
    int b_pulses = 0;
    always @(posedge clk) begin
        if (a_arc4_en) a_pulses <= a_pulses + 1;
        if (b_arc4_en) b_pulses <= b_pulses + 1;
    end

    // Byte i-1 (address i) becomes 0x7F exactly for key i-1, so only key 0x18 survives.
    task automatic load_img_key18();
        for (int i = 0; i < 32; i++) img_a[i] = 8'h00;
        img_a[0] = 8'd24;
        for (int i = 1; i <= 24; i++) img_a[i] = 8'h7F ^ 8'(i - 1);
    endtask

    task automatic start_a();
        @(negedge clk); a_en = 1'b1;
        @(negedge clk); a_en = 1'b0;
    endtask

    task automatic wait_rdy_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_rdy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", a_rdy); else passed++;
        checks++; if (a_kv !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", a_kv); else passed++;
        checks++; if (a_key !== 24'h0) $display("FAIL reset_key: got %h want 000000", a_key); else passed++;
        checks++; if (a_arc4_en !== 1'b0) $display("FAIL reset_arc4_en: got %b want 0", a_arc4_en); else passed++;
        checks++; if (a_arc4_key !== 24'h0) $display("FAIL reset_arc4_key: got %h want 000000", a_arc4_key); else passed++;
        checks++; if (a_pt_addr !== 8'h0) $display("FAIL reset_pt_addr: got %h want 00", a_pt_addr); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_search();
        bit ok; int p0;
        load_img_key18();
        p0 = a_pulses;
        start_a();
        checks++; if (a_rdy !== 1'b0) $display("FAIL search_busy_rdy: got %b want 0", a_rdy); else passed++;
        wait_rdy_a(5000, ok);
        checks++; if (!ok) $display("FAIL search_timeout: rdy got 0 want 1"); else passed++;
        checks++; if (a_kv !== 1'b1) $display("FAIL search_key_valid: got %b want 1", a_kv); else passed++;
        checks++; if (a_key !== 24'h000018) $display("FAIL search_key: got %h want 000018", a_key); else passed++;
        checks++; if (a_pulses - p0 != 25) $display("FAIL search_pulses: got %0d want 25", a_pulses - p0); else passed++;
    endtask

    task automatic test_len_zero();
        bit ok; int p0;
        img_a[0] = 8'd0;
        p0 = a_pulses;
        start_a();
        wait_rdy_a(200, ok);
        checks++; if (!ok) $display("FAIL len0_timeout: rdy got 0 want 1"); else passed++;
        checks++; if (a_kv !== 1'b1) $display("FAIL len0_key_valid: got %b want 1", a_kv); else passed++;
        checks++; if (a_key !== 24'h0) $display("FAIL len0_key: got %h want 000000", a_key); else passed++;
        checks++; if (a_pulses - p0 != 1) $display("FAIL len0_pulses: got %0d want 1", a_pulses - p0); else passed++;
    endtask

    task automatic test_ascii_bounds();
        bit ok; int p0;
        logic [7:0] bytes [0:2];
        logic [23:0] want_key [0:2];
        int want_p [0:2];
        // 0x20/0x7E pass for key 0; 0x7F needs key 1; 0x1F needs key 0x20 (-> 0x3F).
        bytes[0] = 8'h20; want_key[0] = 24'h0;  want_p[0] = 1;
        bytes[1] = 8'h7F; want_key[1] = 24'h1;  want_p[1] = 2;
        bytes[2] = 8'h1F; want_key[2] = 24'h20; want_p[2] = 33;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 32; i++) img_a[i] = 8'h00;
            img_a[0] = (t == 0) ? 8'd2 : 8'd1;
            img_a[1] = bytes[t];
            img_a[2] = 8'h7E;
            p0 = a_pulses;
            start_a();
            wait_rdy_a(3000, ok);
            checks++; if (!ok || a_kv !== 1'b1 || a_key !== want_key[t])
                $display("FAIL bounds_key%0d: got valid=%b key=%h want valid=1 key=%h", t, a_kv, a_key, want_key[t]);
            else passed++;
            checks++; if (a_pulses - p0 != want_p[t])
                $display("FAIL bounds_pulses%0d: got %0d want %0d", t, a_pulses - p0, want_p[t]);
            else passed++;
        end
    endtask

    task automatic test_exhaust();
        bit ok; int p0;
        p0 = b_pulses;
        @(negedge clk); b_en = 1'b1;
        @(negedge clk); b_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b_rdy) begin ok = 1'b1; break; end
        end
        repeat (20) @(negedge clk);
        checks++; if (!ok) $display("FAIL exhaust_timeout: rdy got 0 want 1"); else passed++;
        checks++; if (b_pulses - p0 != 16) $display("FAIL exhaust_pulses: got %0d want 16", b_pulses - p0); else passed++;
        checks++; if (b_kv !== 1'b0) $display("FAIL exhaust_key_valid: got %b want 0", b_kv); else passed++;
        checks++; if (b_arc4_key !== 4'hF) $display("FAIL exhaust_no_wrap: got %h want f", b_arc4_key); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok, hit; int p0;
        load_img_key18();
        start_a();
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (a_arc4_key == 24'd5 && a_pt_addr == 8'd3) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) $display("FAIL rstmid_reach_scan: key5 scan got 0 want 1"); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (a_rdy !== 1'b1 || a_arc4_en !== 1'b0 || a_kv !== 1'b0)
            $display("FAIL rstmid_outputs: got rdy=%b en=%b kv=%b want 1 0 0", a_rdy, a_arc4_en, a_kv);
        else passed++;
        checks++; if (a_arc4_key !== 24'h0) $display("FAIL rstmid_arc4_key: got %h want 000000", a_arc4_key); else passed++;
        // en during reset must not start a search
        a_en = 1'b1;
        @(negedge clk);
        a_en = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (a_rdy !== 1'b1) $display("FAIL rst_beats_en: rdy got %b want 1", a_rdy); else passed++;
        p0 = a_pulses;
        start_a();
        wait_rdy_a(5000, ok);
        checks++; if (!ok || a_key !== 24'h18 || a_pulses - p0 != 25)
            $display("FAIL rstmid_restart: got key=%h pulses=%0d want 000018 25", a_key, a_pulses - p0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok; int p0;
        load_img_key18();
        p0 = a_pulses;
        @(negedge clk); a_en = 1'b1;
        @(negedge clk);
        wait_rdy_a(5000, ok);
        a_en = 1'b0;
        checks++; if (!ok || a_kv !== 1'b1 || a_key !== 24'h18 || a_pulses - p0 != 25)
            $display("FAIL held_en_single: got kv=%b key=%h pulses=%0d want 1 000018 25", a_kv, a_key, a_pulses - p0);
        else passed++;
        // new search resolving to key 1; en pulses while busy must be ignored
        for (int i = 0; i < 32; i++) img_a[i] = 8'h00;
        img_a[0] = 8'd1; img_a[1] = 8'h7F;
        p0 = a_pulses;
        start_a();
        checks++; if (a_kv !== 1'b0) $display("FAIL new_en_clears_valid: got %b want 0", a_kv); else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); a_en = ~a_en;
        end
        a_en = 1'b0;
        wait_rdy_a(500, ok);
        repeat (30) @(negedge clk);
        checks++; if (!ok || a_kv !== 1'b1 || a_key !== 24'h1)
            $display("FAIL busy_en_result: got kv=%b key=%h want 1 000001", a_kv, a_key);
        else passed++;
        checks++; if (a_pulses - p0 != 2) $display("FAIL busy_en_pulses: got %0d want 2", a_pulses - p0); else passed++;
    endtask

    initial begin
        rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
        for (int i = 0; i < 32; i++) img_a[i] = 8'h00;
        test_reset();
        test_search();
        test_len_zero();
        test_ascii_bounds();
        test_exhaust();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
